// File: rtl/ddr_wr_packer.sv
// Packs a 32-bit sample stream into 128-bit write beats and emits one 64-bit
// burst command per burst, placing bursts back-to-back in a DDR ring buffer.
module ddr_wr_packer #(
   parameter int unsigned BURST_LEN = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   s_data,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic          s_last,
   input  logic [48:0]   cfg_base_addr,
   input  logic [15:0]   cfg_ring_bursts,
   output logic [127:0]  fifo_din_wr,
   output logic          fifo_wr_en_wr,
   input  logic          fifo_full_wr,
   output logic [63:0]   fifo_din_cmd,
   output logic          fifo_wr_en_cmd,
   input  logic          fifo_full_cmd,
   output logic          busy,
   output logic          frame_done
);
   localparam int unsigned BURST_BYTES = BURST_LEN * 16;

   typedef enum logic {COLLECT = 1'b0, CMD = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [1:0]    lane_q, lane_d;
   logic [95:0]   lanes_q, lanes_d;
   logic [8:0]    beat_cnt_q, beat_cnt_d;
   logic [15:0]   burst_idx_q, burst_idx_d;
   logic [8:0]    len_q, len_d;
   logic          last_q, last_d;

   logic [8:0]    beat_cnt_inc;
   logic [15:0]   ring_last;
   logic [127:0]  beat;
   logic [48:0]   addr;
   logic [7:0]    len_m1;

   assign beat_cnt_inc = beat_cnt_q + 9'd1;
   assign ring_last    = (cfg_ring_bursts == 16'd0) ? 16'd0 : cfg_ring_bursts - 16'd1;
   // Held lanes above the current one are always zero, so OR-merging is safe.
   assign beat         = {32'd0, lanes_q} | ({96'd0, s_data} << {lane_q, 5'd0});
   assign addr         = cfg_base_addr + 49'(burst_idx_q) * 49'(BURST_BYTES);
   assign len_m1       = 8'(len_q - 9'd1);
   assign busy         = (lane_q != 2'd0) | (beat_cnt_q != 9'd0) | (state_q == CMD);

   always_comb begin
      state_d        = state_q;
      lane_d         = lane_q;
      lanes_d        = lanes_q;
      beat_cnt_d     = beat_cnt_q;
      burst_idx_d    = burst_idx_q;
      len_d          = len_q;
      last_d         = last_q;
      s_ready        = 1'b0;
      fifo_wr_en_wr  = 1'b0;
      fifo_din_wr    = '0;
      fifo_wr_en_cmd = 1'b0;
      fifo_din_cmd   = '0;
      frame_done     = 1'b0;
      case (state_q)
         COLLECT: begin
            s_ready = rst_n & ~fifo_full_wr;
            if (s_valid && s_ready) begin
               if (lane_q == 2'd3 || s_last) begin
                  fifo_wr_en_wr = 1'b1;
                  fifo_din_wr   = beat;
                  lane_d        = 2'd0;
                  lanes_d       = '0;
                  beat_cnt_d    = beat_cnt_inc;
                  // A last sample that also fills the burst closes it only once.
                  if (beat_cnt_inc == 9'(BURST_LEN) || s_last) begin
                     len_d   = beat_cnt_inc;
                     last_d  = s_last;
                     state_d = CMD;
                  end
               end else begin
                  lanes_d[{lane_q, 5'd0} +: 32] = s_data;
                  lane_d = lane_q + 2'd1;
               end
            end
         end
         CMD: begin
            fifo_din_cmd   = {len_m1, 7'd0, addr};
            fifo_wr_en_cmd = ~fifo_full_cmd;
            if (!fifo_full_cmd) begin
               burst_idx_d = (burst_idx_q >= ring_last) ? 16'd0 : burst_idx_q + 16'd1;
               beat_cnt_d  = 9'd0;
               frame_done  = last_q;
               state_d     = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         lane_q      <= 2'd0;
         lanes_q     <= '0;
         beat_cnt_q  <= 9'd0;
         burst_idx_q <= 16'd0;
         len_q       <= 9'd0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         lanes_q     <= lanes_d;
         beat_cnt_q  <= beat_cnt_d;
         burst_idx_q <= burst_idx_d;
         len_q       <= len_d;
         last_q      <= last_d;
      end
   end
endmodule

// File: doc/ddr_wr_packer.md
# ddr_wr_packer

Upstream feeder for a write channel of the PS DDR command/write FIFO pair (channels 0, 1, 2 or 4). It accepts a 32-bit sample stream and packs four samples into each 128-bit beat, pushing beats into the channel's write-data FIFO. After each burst it pushes one 64-bit burst command into the channel's command FIFO. Bursts are laid out back-to-back in a DDR ring buffer.

## Interface
Parameters:
- BURST_LEN, 16, beats per full burst (1..256); BURST_BYTES = BURST_LEN*16 (≤4096)

Ports:
- clk  in  1  single clock domain
- rst_n  in  1  asynchronous, active-low reset
- s_data  in  32  input sample
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid & s_ready
- s_last  in  1  last sample of frame; qualifies the accepted sample
- cfg_base_addr  in  49  ring base byte address; 4 KiB aligned; change only while busy=0
- cfg_ring_bursts  in  16  ring size in bursts; 0 treated as 1
- fifo_din_wr  out  128  write beat
- fifo_wr_en_wr  out  1  write-data FIFO push
- fifo_full_wr  in  1  write-data FIFO full
- fifo_din_cmd  out  64  burst command
- fifo_wr_en_cmd  out  1  command FIFO push
- fifo_full_cmd  in  1  command FIFO full
- busy  out  1  partial beat/burst held, or command pending
- frame_done  out  1  one-cycle pulse when the command for an s_last burst is pushed

## Operation
- States: COLLECT, CMD.
- **COLLECT**
  - s_ready = !fifo_full_wr.
  - Accepted sample goes into lane `lane` (2-bit counter), bits [32*lane+31 : 32*lane], lane 0 first.
- **Beat push**
  - Occurs on the accepting cycle when lane==3 or s_last.
  - fifo_din_wr = held lanes merged with s_data. Unfilled upper lanes are 0.
  - Same cycle: lane←0, beat_cnt+1.
- **Burst close**
  - Condition: beat push with beat_cnt+1 == BURST_LEN, or s_last.
  - Effect: latch len = beats in burst, latch last flag, go to CMD.
- **CMD**
  - s_ready = 0.
  - fifo_wr_en_cmd = !fifo_full_cmd (combinational from state).
  - fifo_din_cmd = {len-1 [63:56], 7'b0 [55:49], addr [48:0]}.
  - addr = cfg_base_addr + burst_idx*BURST_BYTES, 49-bit, no carry out.
- **On command push**
  - burst_idx ← (burst_idx == max(cfg_ring_bursts,1)-1) ? 0 : burst_idx+1.
  - beat_cnt ← 0.
  - frame_done = latched last flag, same cycle as the push.
  - Return to COLLECT.
- **Partial bursts**
  - A partial burst (s_last) still consumes a full ring slot; the next burst starts BURST_BYTES later.
  - burst_idx is not reset between frames.
- **Boundary cases**
  - s_last on a sample that also completes a full burst: one command, len-1 = BURST_LEN-1; no empty command.
  - fifo_full_wr high: no sample accepted, no beat lost; held lanes keep their values.
  - fifo_full_cmd high in CMD: wait indefinitely with all state held.
- busy = (lane != 0) | (beat_cnt != 0) | (state == CMD).

## Timing
- Reset (rst_n low, async), all outputs 0:
  - s_ready, fifo_wr_en_wr, fifo_wr_en_cmd, frame_done, busy = 0.
  - fifo_din_wr, fifo_din_cmd = 0.
  - State COLLECT; lane, beat_cnt, burst_idx = 0.
- First cycle after reset release: s_ready = !fifo_full_wr.
- Reset mid-operation discards held lanes and any pending command; the next frame starts at cfg_base_addr.
- Beat latency: 0 cycles. The beat is pushed in the same cycle as its 4th (or s_last) sample.
- Command latency: pushed in the first cycle after burst close with fifo_full_cmd low; earliest is 1 cycle after the final beat push.
- Throughput: s_ready drops exactly one cycle per burst when the command FIFO is not full.
- No FIFO is ever written while its full input is high.

## Test plan
- **Full burst.** BURST_LEN=16, base 0x0_1000_0000, samples 0..63 streamed continuously.
  - 16 beat pushes; first beat 0x00000003_00000002_00000001_00000000.
  - One command 0x0F00_0000_1000_0000.
  - s_ready low exactly 1 cycle.
- **Short frame.** 6 samples 0..5, s_last on the 6th.
  - Beats {3,2,1,0} and {0,0,5,4}.
  - Command 0x0100_0000_1000_0000, with frame_done pulsed in that cycle.
  - Next frame's command address 0x1000_0100.
- **Ring wrap.** cfg_ring_bursts=2, 3 full bursts → addresses 0x1000_0000, 0x1000_0100, 0x1000_0000.
- **Backpressure.**
  - fifo_full_wr held high 5 cycles mid-beat: no accepts, all samples emerge in order with no loss or duplication.
  - fifo_full_cmd high 4 cycles in CMD: fifo_wr_en_cmd stays 0, then exactly one push.
- **Reset mid-burst.** rst_n pulsed low after 37 samples.
  - Outputs 0 immediately, busy 0.
  - Next 64 samples produce a command at 0x1000_0000 with len 15.
- **s_last edge cases.**
  - s_last on sample 64 of a burst: one command, len 15, one frame_done.
  - s_last on a lone sample: beat {0,0,0,x}, command len field 0x00.
